fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
// - Producer side of the instruction buffer interface: issues word fetches to instruction memory and
//   delivers each returned 32-bit word, tagged with its word-aligned PC, to the instruction buffer.
// - Holds one response while the buffer is stalled, handles redirects (clear + halfword align) and drains
//   the one request that may still be in flight. Sits between the fetch-side memory port and the buffer.
// PARAMETERS
// - RESET_PC  32'h0000_0000  first fetch PC after reset; bit 1 selects the initial halfword alignment
// PORTS
// - clock           in   1   single clock, rising edge
// - reset           in   1   asynchronous, active-high reset
// - redirect_valid  in   1   branch/jump/trap redirect this cycle
// - redirect_pc     in   32  redirect target, halfword aligned (bit 0 ignored)
// - imem_valid      out  1   fetch request valid; held high until imem_ready
// - imem_addr       out  32  fetch address, always word aligned (bits 1:0 = 0)
// - imem_ready      in   1   request complete; imem_rdata valid in the same cycle
// - imem_rdata      in   32  fetched word
// - buf_stall       in   1   buffer registered stall; buf_ready is ignored by the buffer while high
// - buf_ready       out  1   buf_rdata/buf_pc valid; buffer writes two halfwords
// - buf_rdata       out  32  word to buffer
// - buf_pc          out  32  word-aligned PC of buf_rdata
// - buf_clear       out  1   flush buffer pointers and counts
// - buf_align       out  1   with buf_clear: 1 = start at the upper halfword (target PC[1])
// BEHAVIOUR
// - Reset: every output is 0; state=START; pc_q={RESET_PC[31:2],2'b00}; hold_v=0.
// - States: START, FETCH, HOLD, DRAIN.
// - START, one cycle: buf_clear=1, buf_align=RESET_PC[1], imem_valid=0; next state FETCH.
// - FETCH: imem_valid=1, imem_addr=pc_q.
//   - imem_ready & !buf_stall: buf_ready=1, buf_rdata=imem_rdata, buf_pc=pc_q (combinational, 0 latency);
//     pc_q+=4.
//   - imem_ready & buf_stall: capture hold_data=imem_rdata, hold_pc=pc_q, hold_v=1; pc_q+=4; go to HOLD.
// - HOLD: imem_valid=0. When buf_stall=0: buf_ready=1 with hold_data/hold_pc; hold_v=0; go to FETCH.
//   The next request issues in the following cycle.
// - Redirect, in any state except START, has highest priority:
//   - buf_clear=1, buf_align=redirect_pc[1], buf_ready=0, hold_v=0, pc_q={redirect_pc[31:2],2'b00}.
//   - In FETCH with imem_ready=0: save the old address and go to DRAIN.
//   - Otherwise (response arriving that cycle, or no request open): drop any response; go to FETCH.
// - DRAIN: imem_valid=1 with the saved old address until imem_ready; discard that response
//   (buf_ready=0); then go to FETCH at pc_q.
//   - A further redirect in DRAIN updates pc_q, buf_clear and buf_align and stays in DRAIN.
// - Redirect in START: ignored (START clear already pending); redirect_valid is not asserted then.
// - pc_q wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
// - At most one request outstanding. imem_addr is stable while imem_valid=1 and imem_ready=0.
// - buf_ready never asserts in a buf_clear cycle, and never while buf_stall=1.
// - Reset asserted mid-transaction: immediate return to reset values; any late imem_ready is not expected.
// CONFIGURATION
// - FETCH_PERF_EN defined: extra outputs perf_fetch (32) and perf_stall (32), reset 0, wrapping.
//   - perf_fetch: +1 per buf_ready cycle.
//   - perf_stall: +1 per cycle in HOLD.
// - FETCH_PERF_EN undefined: ports and counters absent; remaining behaviour identical.
// TESTING
// - RESET_PC=0x100, memory returns ready every cycle, buf_stall=0 -> START clear with align=0, then
//   buf_pc 0x100, 0x104, 0x108 on consecutive buf_ready.
// - RESET_PC=0x102 -> START: buf_clear=1, buf_align=1; first imem_addr=0x100.
// - buf_stall=1 when word 0x104 returns -> HOLD, imem_valid=0; buf_stall falls 3 cycles later ->
//   buf_ready with 0x104, then request 0x108.
// - Redirect to 0x206 while request 0x10C pending 2 more cycles -> clear, align=1; imem_addr stays 0x10C
//   until ready, data dropped; next request 0x204.
// - Redirect same cycle as imem_ready and buf_stall=1 -> no buf_ready, no HOLD, hold_v=0; next
//   request at the target.
// - FETCH_PERF_EN: 10 delivered words and 4 HOLD cycles -> perf_fetch=10, perf_stall=4.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch producer: issues word fetches and hands returned words, tagged with their PC, to the
// instruction buffer. Optional counters perf_fetch/perf_stall are built when FETCH_PERF_EN is defined.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_valid,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        buf_stall,
  output logic        buf_ready,
  output logic [31:0] buf_rdata,
  output logic [31:0] buf_pc,
  output logic        buf_clear,
  output logic        buf_align
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_stall
`endif
);

  typedef enum logic [1:0] {START, FETCH, HOLD, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q, pc_nxt;
  logic [31:0] drain_addr, drain_nxt;
  logic [31:0] hold_data, hold_pc;
  logic        hold_v, hold_v_nxt;
  logic        capture;
  logic [31:0] redirect_word;
  logic        unused_pc_bit;

  assign redirect_word = {redirect_pc[31:2], 2'b00};
  assign unused_pc_bit = redirect_pc[0];

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc_q;
    drain_nxt  = drain_addr;
    hold_v_nxt = hold_v;
    capture    = 1'b0;
    imem_valid = 1'b0;
    imem_addr  = 32'd0;
    buf_ready  = 1'b0;
    buf_rdata  = 32'd0;
    buf_pc     = 32'd0;
    buf_clear  = 1'b0;
    buf_align  = 1'b0;
    case (state)
      START: begin
        // While reset is held the machine sits here, so outputs are masked to stay 0.
        buf_clear = !reset;
        buf_align = !reset && RESET_PC[1];
        state_nxt = FETCH;
      end
      FETCH: begin
        imem_valid = 1'b1;
        imem_addr  = pc_q;
        if (redirect_valid) begin
          buf_clear = 1'b1;
          buf_align = redirect_pc[1];
          pc_nxt    = redirect_word;
          // An open request must finish at its original address before the target is fetched.
          if (!imem_ready) begin
            drain_nxt = pc_q;
            state_nxt = DRAIN;
          end
        end else if (imem_ready) begin
          pc_nxt = pc_q + 32'd4;
          if (!buf_stall) begin
            buf_ready = 1'b1;
            buf_rdata = imem_rdata;
            buf_pc    = pc_q;
          end else begin
            capture    = 1'b1;
            hold_v_nxt = 1'b1;
            state_nxt  = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          buf_clear  = 1'b1;
          buf_align  = redirect_pc[1];
          pc_nxt     = redirect_word;
          hold_v_nxt = 1'b0;
          state_nxt  = FETCH;
        end else if (hold_v && !buf_stall) begin
          buf_ready  = 1'b1;
          buf_rdata  = hold_data;
          buf_pc     = hold_pc;
          hold_v_nxt = 1'b0;
          state_nxt  = FETCH;
        end
      end
      DRAIN: begin
        imem_valid = 1'b1;
        imem_addr  = drain_addr;
        if (redirect_valid) begin
          buf_clear = 1'b1;
          buf_align = redirect_pc[1];
          pc_nxt    = redirect_word;
        end
        if (imem_ready) state_nxt = FETCH;
      end
      default: state_nxt = START;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= START;
      pc_q       <= {RESET_PC[31:2], 2'b00};
      drain_addr <= 32'd0;
      hold_v     <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc_q       <= pc_nxt;
      drain_addr <= drain_nxt;
      hold_v     <= hold_v_nxt;
    end
  end

  // Held word is qualified by hold_v, so the data registers need no reset.
  always_ff @(posedge clock) begin
    if (capture) begin
      hold_data <= imem_rdata;
      hold_pc   <= pc_q;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_fetch <= 32'd0;
      perf_stall <= 32'd0;
    end else begin
      if (buf_ready)     perf_fetch <= perf_fetch + 32'd1;
      if (state == HOLD) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
